// File: rtl/pipe_test_pkg.sv
// Constants and pattern encodings shared by the PipeTest Pipe In/Pipe Out blocks.
package pipe_test_pkg;

    localparam int unsigned PIPE_WIDTH          = 32;
    localparam int unsigned FIFO_DEPTH_DEFAULT  = 65535;
    localparam int unsigned READY_SPACE_DEFAULT = 1024;

    // Pattern generator modes; unlisted encodings produce a constant zero stream.
    typedef enum logic [2:0] {
        PatCount = 3'd0,  // incrementing counter from 0
        PatLfsr  = 3'd1,  // x^32+x^22+x^2+x+1 shift register, seed 1
        PatWalk1 = 3'd2,  // single one rotating left from bit 0
        PatWalk0 = 3'd3,  // single zero rotating left from bit 0
        PatAlt   = 3'd4   // 0xAAAA.. / 0x5555.. alternating
    } pattern_e;

endpackage

// File: rtl/pattern_gen.sv
// Deterministic word stream generator; advances one step per enabled cycle.
module pattern_gen
    import pipe_test_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [2:0]       mode,
    output logic [WIDTH-1:0] dout
);

    localparam logic [WIDTH-1:0] LFSR_TAPS = WIDTH'(32'h8020_0003);
    localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);

    logic [WIDTH-1:0] state;
    logic [WIDTH-1:0] state_next;
    logic [WIDTH-1:0] seed;

    // Seed and successor for the selected mode.
    always_comb begin
        seed       = '0;
        state_next = state;
        case (pattern_e'(mode))
            PatCount: begin
                seed       = '0;
                state_next = state + ONE;
            end
            PatLfsr: begin
                seed       = ONE;
                state_next = {state[WIDTH-2:0], ^(state & LFSR_TAPS)};
            end
            PatWalk1: begin
                seed       = ONE;
                state_next = {state[WIDTH-2:0], state[WIDTH-1]};
            end
            PatWalk0: begin
                seed       = ~ONE;
                state_next = {state[WIDTH-2:0], state[WIDTH-1]};
            end
            PatAlt: begin
                seed       = {(WIDTH / 2){2'b10}};
                state_next = ~state;
            end
            default: begin
                seed       = '0;
                state_next = '0;
            end
        endcase
    end

    // Restart from the seed on reset, step on enable.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= seed;
        end else if (enable) begin
            state <= state_next;
        end
    end

    assign dout = state;

endmodule

// File: rtl/pipe_in_verify.sv
// Pipe In consumer: checks host words against pattern_gen and models FIFO flow control.
module pipe_in_verify
    import pipe_test_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH  = FIFO_DEPTH_DEFAULT,
    parameter int unsigned READY_SPACE = READY_SPACE_DEFAULT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  pipe_in_write,
    input  logic [PIPE_WIDTH-1:0] pipe_in_data,
    output logic                  pipe_in_ready,
    input  logic                  throttle_set,
    input  logic [31:0]           throttle_val,
    input  logic [2:0]            pattern,
    output logic [31:0]           word_count,
    output logic [31:0]           error_count,
    output logic [31:0]           first_err_index,
    output logic [PIPE_WIDTH-1:0] first_err_actual,
    output logic [PIPE_WIDTH-1:0] first_err_expected,
    output logic                  overflow
);

    localparam logic [15:0] DEPTH_LVL = 16'(FIFO_DEPTH);
    localparam logic [15:0] READY_LVL = 16'(READY_SPACE);

    logic [PIPE_WIDTH-1:0] expected;
    logic [31:0]           throttle;
    logic [15:0]           level;
    logic                  wr_d;
    logic [PIPE_WIDTH-1:0] data_d;
    logic [PIPE_WIDTH-1:0] exp_d;
    logic                  mismatch;

    pattern_gen #(
        .WIDTH (PIPE_WIDTH)
    ) u_pattern_gen (
        .clk    (clk),
        .reset  (reset),
        .enable (pipe_in_write),
        .mode   (pattern),
        .dout   (expected)
    );

    // Throttle pattern: load on set (and reset), otherwise rotate right each cycle.
    always_ff @(posedge clk) begin
        if (reset || throttle_set) begin
            throttle <= throttle_val;
        end else begin
            throttle <= {throttle[0], throttle[31:1]};
        end
    end

    // Virtual FIFO level: writes fill, throttle bit 0 drains; simultaneous events cancel.
    always_ff @(posedge clk) begin
        if (reset) begin
            level    <= '0;
            overflow <= 1'b0;
        end else begin
            case ({pipe_in_write, throttle[0]})
                2'b10: begin
                    if (level == DEPTH_LVL) begin
                        overflow <= 1'b1;
                    end else begin
                        level <= level + 16'd1;
                    end
                end
                2'b01: begin
                    if (level != 16'd0) begin
                        level <= level - 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Ready reflects the level as it stood before this edge's update.
    always_ff @(posedge clk) begin
        if (reset) begin
            pipe_in_ready <= 1'b0;
        end else begin
            pipe_in_ready <= (DEPTH_LVL - level) >= READY_LVL;
        end
    end

    // Compare stage 1: capture the write alongside its expected word.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_d   <= 1'b0;
            data_d <= '0;
            exp_d  <= '0;
        end else begin
            wr_d   <= pipe_in_write;
            data_d <= pipe_in_data;
            exp_d  <= expected;
        end
    end

    assign mismatch = data_d != exp_d;

    // Compare stage 2: saturating counters and first-mismatch capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            word_count         <= '0;
            error_count        <= '0;
            first_err_index    <= '0;
            first_err_actual   <= '0;
            first_err_expected <= '0;
        end else if (wr_d) begin
            if (word_count != '1) begin
                word_count <= word_count + 32'd1;
            end
            if (mismatch) begin
                if (error_count != '1) begin
                    error_count <= error_count + 32'd1;
                end
                if (error_count == '0) begin
                    first_err_index    <= word_count;
                    first_err_actual   <= data_d;
                    first_err_expected <= exp_d;
                end
            end
        end
    end

endmodule

// File: tb/tb_pipe_in_verify.sv
// Directed bench for pipe_in_verify: table of pattern streams plus flow/overflow/reset sequences.
module tb_pipe_in_verify;
    import pipe_test_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        pipe_in_write = 1'b0;
    logic [31:0] pipe_in_data = '0;
    logic        pipe_in_ready;
    logic        throttle_set = 1'b0;
    logic [31:0] throttle_val = 32'hFFFF_FFFF;
    logic [2:0]  pattern = 3'd0;
    logic [31:0] word_count;
    logic [31:0] error_count;
    logic [31:0] first_err_index;
    logic [31:0] first_err_actual;
    logic [31:0] first_err_expected;
    logic        overflow;

    int errors = 0;
    int checks = 0;

    // Bench-side pattern model state.
    logic [31:0] lf_m = 32'd1;
    int          widx = 0;
    logic        fe_seen = 1'b0;
    logic [31:0] fe_act = '0;
    logic [31:0] fe_exp = '0;

    typedef struct {
        logic [2:0]  mode;
        int          n;
        int          ca;
        int          cb;
        logic [31:0] exp_wc;
        logic [31:0] exp_ec;
        logic [31:0] exp_idx;
    } vec_t;

    vec_t vecs [6];

    pipe_in_verify dut (
        .clk                (clk),
        .reset              (reset),
        .pipe_in_write      (pipe_in_write),
        .pipe_in_data       (pipe_in_data),
        .pipe_in_ready      (pipe_in_ready),
        .throttle_set       (throttle_set),
        .throttle_val       (throttle_val),
        .pattern            (pattern),
        .word_count         (word_count),
        .error_count        (error_count),
        .first_err_index    (first_err_index),
        .first_err_actual   (first_err_actual),
        .first_err_expected (first_err_expected),
        .overflow           (overflow)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
    endfunction

    function automatic logic [31:0] model_word(input logic [2:0] m, input int i,
                                               input logic [31:0] lf);
        logic [31:0] one_hot;
        one_hot = 32'h1 << (i % 32);
        case (m)
            3'd0:    return 32'(i);
            3'd1:    return lf;
            3'd2:    return one_hot;
            3'd3:    return ~one_hot;
            3'd4:    return (i % 2 == 1) ? 32'h5555_5555 : 32'hAAAA_AAAA;
            default: return 32'h0;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset(input logic [2:0] m, input logic [31:0] tv);
        @(negedge clk);
        reset         = 1'b1;
        pipe_in_write = 1'b0;
        throttle_set  = 1'b0;
        pattern       = m;
        throttle_val  = tv;
        @(negedge clk);
        reset   = 1'b0;
        lf_m    = 32'd1;
        widx    = 0;
        fe_seen = 1'b0;
        fe_act  = '0;
        fe_exp  = '0;
    endtask

    // Back-to-back writes; words at absolute indices ca/cb get bit 0 flipped.
    task automatic write_words(input int n, input int ca, input int cb);
        logic [31:0] e;
        logic [31:0] d;
        for (int k = 0; k < n; k++) begin
            e = model_word(pattern, widx, lf_m);
            d = (widx == ca || widx == cb) ? (e ^ 32'h1) : e;
            if (d != e && !fe_seen) begin
                fe_seen = 1'b1;
                fe_act  = d;
                fe_exp  = e;
            end
            @(negedge clk);
            pipe_in_write = 1'b1;
            pipe_in_data  = d;
            lf_m = lfsr_step(lf_m);
            widx++;
        end
        @(negedge clk);
        pipe_in_write = 1'b0;
    endtask

    initial begin
        vecs[0] = '{3'd0, 2048, -1, -1, 32'd2048, 32'd0, 32'd0};
        vecs[1] = '{3'd0, 16,    5, -1, 32'd16,   32'd1, 32'd5};
        vecs[2] = '{3'd1, 16,    3,  9, 32'd16,   32'd2, 32'd3};
        vecs[3] = '{3'd2, 40,   33, -1, 32'd40,   32'd1, 32'd33};
        vecs[4] = '{3'd3, 8,     0, -1, 32'd8,    32'd1, 32'd0};
        vecs[5] = '{3'd4, 6,     1,  2, 32'd6,    32'd2, 32'd1};

        // Reset state, then ready one cycle after release.
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_ready", {31'd0, pipe_in_ready}, 32'd0);
        check("rst_wc", word_count, 32'd0);
        check("rst_ec", error_count, 32'd0);
        check("rst_fidx", first_err_index, 32'd0);
        check("rst_fact", first_err_actual, 32'd0);
        check("rst_fexp", first_err_expected, 32'd0);
        check("rst_ovf", {31'd0, overflow}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("ready_after_rst", {31'd0, pipe_in_ready}, 32'd1);

        // Table of streams with throttle fully draining (level stays 0).
        for (int v = 0; v < 6; v++) begin
            do_reset(vecs[v].mode, 32'hFFFF_FFFF);
            write_words(vecs[v].n, vecs[v].ca, vecs[v].cb);
            repeat (2) @(negedge clk);
            check($sformatf("v%0d_wc", v), word_count, vecs[v].exp_wc);
            check($sformatf("v%0d_ec", v), error_count, vecs[v].exp_ec);
            check($sformatf("v%0d_fidx", v), first_err_index, vecs[v].exp_idx);
            check($sformatf("v%0d_fact", v), first_err_actual, fe_seen ? fe_act : 32'd0);
            check($sformatf("v%0d_fexp", v), first_err_expected, fe_seen ? fe_exp : 32'd0);
            check($sformatf("v%0d_ovf", v), {31'd0, overflow}, 32'd0);
            check($sformatf("v%0d_ready", v), {31'd0, pipe_in_ready}, 32'd1);
        end

        // Mid-stream reset discards in-flight compares and restarts the pattern.
        do_reset(3'd1, 32'hFFFF_FFFF);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            pipe_in_write = 1'b1;
            pipe_in_data  = model_word(3'd1, k, lf_m) ^ ((k == 2) ? 32'h1 : 32'h0);
            lf_m = lfsr_step(lf_m);
        end
        @(negedge clk);
        reset        = 1'b1;
        pipe_in_data = 32'hDEAD_BEEF;
        @(negedge clk);
        check("mid_rst_wc", word_count, 32'd0);
        check("mid_rst_ec", error_count, 32'd0);
        check("mid_rst_fidx", first_err_index, 32'd0);
        check("mid_rst_fact", first_err_actual, 32'd0);
        reset         = 1'b0;
        pipe_in_write = 1'b0;
        lf_m    = 32'd1;
        widx    = 0;
        fe_seen = 1'b0;
        write_words(4, -1, -1);
        repeat (2) @(negedge clk);
        check("post_rst_wc", word_count, 32'd4);
        check("post_rst_ec", error_count, 32'd0);

        // Flow control: no drain, fill to 64512, ready drops one cycle after.
        do_reset(3'd0, 32'h0);
        write_words(64512, -1, -1);
        check("fill_ready_before", {31'd0, pipe_in_ready}, 32'd1);
        @(negedge clk);
        check("fill_ready_low", {31'd0, pipe_in_ready}, 32'd0);

        // Exactly one drain: throttle all-ones for one cycle, then zero.
        throttle_set = 1'b1;
        throttle_val = 32'hFFFF_FFFF;
        @(negedge clk);
        throttle_val = 32'h0;
        @(negedge clk);
        throttle_set = 1'b0;
        check("drain_ready_lag", {31'd0, pipe_in_ready}, 32'd0);
        @(negedge clk);
        check("drain_ready_back", {31'd0, pipe_in_ready}, 32'd1);

        // Fill to the ceiling, then one overflowing (corrupted) write.
        write_words(1024, -1, -1);
        repeat (2) @(negedge clk);
        check("full_ovf_clear", {31'd0, overflow}, 32'd0);
        check("full_ready", {31'd0, pipe_in_ready}, 32'd0);
        write_words(1, 65536, -1);
        repeat (2) @(negedge clk);
        check("ovf_set", {31'd0, overflow}, 32'd1);
        check("ovf_wc", word_count, 32'd65537);
        check("ovf_ec", error_count, 32'd1);
        check("ovf_fidx", first_err_index, 32'd65536);
        check("ovf_fact", first_err_actual, 32'd65536 ^ 32'd1);
        check("ovf_fexp", first_err_expected, 32'd65536);
        repeat (3) @(negedge clk);
        check("ovf_level_held", {31'd0, pipe_in_ready}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
